pwl_pipe_mc: RTL and testbench
==============================

// Module: pwl_pipe_mc
// PURPOSE
//  Pipelined, multi-channel piecewise-linear (PWL) evaluator; next generation of the single-channel pwl.
//  Maps a fixed-point input (e.g. dt since pulse edge) to bias[seg] + slope[seg]*offset.
//  Uses ROM tables selected by a per-channel RX setting, with valid/ready flow control.
//  Sits between the time generator and the filter-step accumulator.
//  One sample per cycle, shared by N_CH channels via channel tag.
// PARAMETERS
//  segment_rom_name  "seg.mem"  slope ROM file ($readmemb), n_settings*2^addr_width words
//  bias_rom_name     "bias.mem" bias ROM file ($readmemb), same depth and indexing
//  n_ch              4    number of channels
//  n_settings        16   settings per table
//  setting_width     4    width of a setting index
//  in_width          16   unsigned input width;  in_point 8: input binary point
//  addr_width        4    segment address bits;  addr_offset 0: input value of segment 0 start
//  segment_width     6    offset bits within a segment
//  slope_width       18   signed slope width;   slope_point 12: slope binary point
//  bias_width        18   signed bias width;    stored at out_point
//  out_width         18   signed output width;  out_point 12: output binary point
// PORTS
//  clk          in   1                        clock
//  rst_n        in   1                        async active-low reset
//  in_valid     in   1                        input sample valid
//  in_ready     out  1                        block accepts sample this cycle
//  in           in   in_width                 input value (unsigned, in_point)
//  in_ch        in   $clog2(n_ch)             channel tag of input
//  cfg_we       in   1                        write per-channel setting
//  cfg_ch       in   $clog2(n_ch)             channel to configure
//  cfg_setting  in   setting_width            new setting value
//  out_valid    out  1                        result valid
//  out_ready    in   1                        downstream accepts result
//  out          out  out_width                result (signed, out_point)
//  out_ch       out  $clog2(n_ch)             channel tag of result
//  clamp_lo / clamp_hi / sat  out 1 each      input below range / above range / output saturated
// BEHAVIOUR
//  Reset: out_valid=0, out=0, out_ch=0, all flags=0, every setting reg=0, all stage valids=0.
//  Pipeline: S1 index calc + ROM addr; S2 sync ROM read; S3 multiply + add + saturate -> out regs.
//  Latency: accepted on edge N -> out_valid on edge N+3 when no stall.
//  Flow: adv = !out_valid | out_ready; in_ready = adv. All stages hold when !adv.
//  Accept = in_valid & in_ready. Data, out and flags remain stable while out_valid & !out_ready.
//  Setting: setting_reg[in_ch] sampled at accept and carried with the sample.
//   cfg_we updates setting_reg[cfg_ch] on the edge.
//   Same-cycle cfg_we and accept on the same channel: the accepted sample uses the OLD setting.
//   In-flight samples never change setting. cfg_setting >= n_settings is clamped to n_settings-1.
//  Arithmetic: idx = in - addr_offset (signed, in_width+1 bits).
//   idx<0: addr=0, off=0, clamp_lo=1.
//   idx >= 2^(addr_width+segment_width): addr=all ones, off=all ones, clamp_hi=1.
//   Otherwise: addr = idx[addr_width+segment_width-1:segment_width], off = idx[segment_width-1:0].
//   ROM index = setting*2^addr_width + addr.
//   prod = slope*off (full width), arithmetic shift right by slope_point+in_point-out_point.
//    Shift truncates toward -inf; a negative shift amount is a left shift.
//   sum = bias + shifted prod, full width; saturated to out_width two's-complement range; sat=1 when clipped.
//  Reset mid-operation: all in-flight samples dropped; no out_valid until 3 edges after first new accept.
// TESTING (n_ch=2, in_width=8, in_point=4, slope_point=4, out_point=4, out_width=8,
//          segment_width=3, addr_width=2, addr_offset=8;
//          setting0: bias={0,16,32,48}, slope={16,16,16,16}; setting1: bias[0]=120, slope[0]=127)
//  1 in=13,ch0,setting0, out_ready=1 -> 3 cycles later out=5, out_ch=0, flags 0.
//  2 back-to-back in=19 then 13, ch1 -> out=19 then 5 on consecutive cycles; throughput 1/cycle.
//  3 in=4 -> out=0, clamp_lo=1.  in=40 -> out=55, clamp_hi=1.
//  4 cfg_we ch0 setting=1, same cycle accept in=15 ch0 -> that sample out=7 (old setting).
//    Next in=15 ch0 -> 120+55 saturates: out=127, sat=1.
//  5 hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after pipe full.
//    out stable, no sample lost or duplicated; release -> in-order drain.
//  6 assert rst_n=0 with 3 samples in flight -> out_valid=0 immediately, settings=0; none emerge after release.

Source files
------------

// File: rtl/pwl_pipe_mc.sv
// ---------------------------------------------------------------------------
// pwl_pipe_mc
//
// Pipelined, multi-channel piecewise-linear evaluator. Each input sample is
// mapped to bias[seg] + slope[seg]*offset. The slope and bias tables are
// selected by a per-channel setting register. One sample per cycle is
// accepted, and the sample carries its channel tag through the pipe.
//
// Pipeline (every register advances only when adv is high):
//   capture : accepted sample, channel and its setting (read at accept)
//   S1      : segment index calc, clamping, ROM address
//   S2      : synchronous ROM read of slope and bias
//   S3      : multiply, shift, add, saturate into the output registers
// A sample accepted on edge N shows out_valid on edge N+3.
//
// The slope/bias ROM contents are given as flat parameter vectors. Entry k
// occupies bits [k*width +: width], and k = setting*2^addr_width + addr.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in/in_ch input handshake, unsigned value, channel tag
//   cfg_we/cfg_ch/cfg_setting  per-channel setting write
//   out_valid/out_ready        output handshake
//   out/out_ch                 signed result, channel tag
//   clamp_lo/clamp_hi/sat      input below range / above range / saturated
// ---------------------------------------------------------------------------
module pwl_pipe_mc #(
    parameter int n_ch          = 4,
    parameter int n_settings    = 16,
    parameter int setting_width = 4,
    parameter int in_width      = 16,
    parameter int in_point      = 8,
    parameter int addr_width    = 4,
    parameter int addr_offset   = 0,
    parameter int segment_width = 6,
    parameter int slope_width   = 18,
    parameter int slope_point   = 12,
    parameter int bias_width    = 18,
    parameter int out_width     = 18,
    parameter int out_point     = 12,
    parameter logic [n_settings*(1<<addr_width)*slope_width-1:0] slope_table = '0,
    parameter logic [n_settings*(1<<addr_width)*bias_width-1:0]  bias_table  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [in_width-1:0]          in,
    input  logic [$clog2(n_ch)-1:0]      in_ch,
    input  logic                         cfg_we,
    input  logic [$clog2(n_ch)-1:0]      cfg_ch,
    input  logic [setting_width-1:0]     cfg_setting,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [out_width-1:0]  out,
    output logic [$clog2(n_ch)-1:0]      out_ch,
    output logic                         clamp_lo,
    output logic                         clamp_hi,
    output logic                         sat
);

    localparam int ch_width      = $clog2(n_ch);
    localparam int span_bits     = addr_width + segment_width;
    localparam int idx_width     = in_width + 1;
    localparam int rom_idx_width = setting_width + addr_width;
    localparam int rom_depth     = 1 << rom_idx_width;
    localparam int table_entries = n_settings << addr_width;
    localparam int shift         = slope_point + in_point - out_point;
    localparam int left_shift    = (shift < 0) ? -shift : 0;
    localparam int prod_width    = slope_width + segment_width + 1;
    localparam int wide_a        = (bias_width > prod_width + left_shift) ? bias_width : prod_width + left_shift;
    localparam int wide_width    = ((wide_a > out_width) ? wide_a : out_width) + 1;

    localparam logic [setting_width-1:0] max_setting = setting_width'(n_settings - 1);
    localparam logic signed [wide_width-1:0] out_max =
        (wide_width'(1) <<< (out_width - 1)) - wide_width'(1);
    localparam logic signed [wide_width-1:0] out_min = ~out_max;

    logic                        adv;
    logic                        accept;
    logic [setting_width-1:0]    setting_reg [n_ch];
    logic [setting_width-1:0]    cfg_clamped;

    logic                        s0_valid;
    logic [in_width-1:0]         s0_in;
    logic [ch_width-1:0]         s0_ch;
    logic [setting_width-1:0]    s0_setting;

    logic signed [idx_width-1:0] idx;
    logic                        idx_lo;
    logic                        idx_hi;
    logic [addr_width-1:0]       idx_addr;
    logic [segment_width-1:0]    idx_off;

    logic                        s1_valid;
    logic [ch_width-1:0]         s1_ch;
    logic [rom_idx_width-1:0]    s1_rom_idx;
    logic [segment_width-1:0]    s1_off;
    logic                        s1_lo;
    logic                        s1_hi;

    logic signed [slope_width-1:0] slope_rom [rom_depth];
    logic signed [bias_width-1:0]  bias_rom  [rom_depth];

    logic                          s2_valid;
    logic [ch_width-1:0]           s2_ch;
    logic signed [slope_width-1:0] s2_slope;
    logic signed [bias_width-1:0]  s2_bias;
    logic [segment_width-1:0]      s2_off;
    logic                          s2_lo;
    logic                          s2_hi;

    logic signed [wide_width-1:0]  prod;
    logic signed [wide_width-1:0]  prod_shifted;
    logic signed [wide_width-1:0]  sum;

    // The whole pipe moves as one: it advances whenever the output register
    // is empty or being drained, so a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // Out-of-range setting writes select the last table instead of
    // indexing past the populated part of the ROM.
    assign cfg_clamped = (cfg_setting > max_setting) ? max_setting : cfg_setting;

    // Unpack the flat table parameters into ROM arrays. Addresses that a
    // clamped setting can never reach read as zero.
    for (genvar k = 0; k < rom_depth; k++) begin : g_rom
        if (k < table_entries) begin : g_used
            assign slope_rom[k] = slope_table[k*slope_width +: slope_width];
            assign bias_rom[k]  = bias_table[k*bias_width +: bias_width];
        end else begin : g_unused
            assign slope_rom[k] = '0;
            assign bias_rom[k]  = '0;
        end
    end

    // Per-channel setting registers. The capture stage reads the register
    // before this edge updates it, so a write on the same edge as an accept
    // on that channel only affects later samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < n_ch; i++) begin
                setting_reg[i] <= '0;
            end
        end else if (cfg_we) begin
            setting_reg[cfg_ch] <= cfg_clamped;
        end
    end

    // Capture stage: latch the accepted sample together with the setting of
    // its channel, so the setting can no longer change while it is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid   <= 1'b0;
            s0_in      <= '0;
            s0_ch      <= '0;
            s0_setting <= '0;
        end else if (adv) begin
            s0_valid <= accept;
            if (accept) begin
                s0_in      <= in;
                s0_ch      <= in_ch;
                s0_setting <= setting_reg[in_ch];
            end
        end
    end

    // Segment index: below the offset clamps to the start of segment 0,
    // past the last segment clamps to the final offset of the last segment.
    assign idx      = $signed({1'b0, s0_in}) - $signed(idx_width'(addr_offset));
    assign idx_lo   = idx[idx_width-1];
    assign idx_hi   = !idx_lo && ((idx[idx_width-2:0] >> span_bits) != '0);
    assign idx_addr = idx_lo ? '0 : (idx_hi ? '1 : idx[span_bits-1:segment_width]);
    assign idx_off  = idx_lo ? '0 : (idx_hi ? '1 : idx[segment_width-1:0]);

    // S1: register the ROM address (setting selects the table, addr the
    // segment within it) and carry the offset and clamp flags along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_ch      <= '0;
            s1_rom_idx <= '0;
            s1_off     <= '0;
            s1_lo      <= 1'b0;
            s1_hi      <= 1'b0;
        end else if (adv) begin
            s1_valid   <= s0_valid;
            s1_ch      <= s0_ch;
            s1_rom_idx <= {s0_setting, idx_addr};
            s1_off     <= idx_off;
            s1_lo      <= idx_lo;
            s1_hi      <= idx_hi;
        end
    end

    // S2: synchronous ROM read of slope and bias for the selected segment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_ch    <= '0;
            s2_slope <= '0;
            s2_bias  <= '0;
            s2_off   <= '0;
            s2_lo    <= 1'b0;
            s2_hi    <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_ch    <= s1_ch;
            s2_slope <= slope_rom[s1_rom_idx];
            s2_bias  <= bias_rom[s1_rom_idx];
            s2_off   <= s1_off;
            s2_lo    <= s1_lo;
            s2_hi    <= s1_hi;
        end
    end

    // Everything below is done at a width wide enough that nothing wraps
    // before the saturation check. The arithmetic right shift floors toward
    // minus infinity; a negative shift amount becomes a left shift.
    assign prod = wide_width'(s2_slope) * wide_width'($signed({1'b0, s2_off}));

    if (shift >= 0) begin : g_shift_right
        assign prod_shifted = prod >>> shift;
    end else begin : g_shift_left
        assign prod_shifted = prod <<< left_shift;
    end

    assign sum = wide_width'(s2_bias) + prod_shifted;

    // S3: saturate into the output registers. Output data only changes when
    // a valid sample moves in, so it stays put while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_ch    <= '0;
            clamp_lo  <= 1'b0;
            clamp_hi  <= 1'b0;
            sat       <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_ch   <= s2_ch;
                clamp_lo <= s2_lo;
                clamp_hi <= s2_hi;
                if (sum > out_max) begin
                    out <= out_max[out_width-1:0];
                    sat <= 1'b1;
                end else if (sum < out_min) begin
                    out <= out_min[out_width-1:0];
                    sat <= 1'b1;
                end else begin
                    out <= sum[out_width-1:0];
                    sat <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwl_pipe_mc.sv
// ---------------------------------------------------------------------------
// tb_pwl_pipe_mc
//
// Directed bench for pwl_pipe_mc in a small configuration: two channels,
// 8-bit input and output with 4 fractional bits, 4 segments of 8 steps
// starting at input 8. Setting 0 is a unit-slope ramp with bias steps of
// 16; setting 1 has bias 120 and slope 127 in segment 0.
// Expected results come from a small reference model and sit in a queue
// from accept until the DUT hands the result over.
// ---------------------------------------------------------------------------
module tb_pwl_pipe_mc;

    localparam logic [143:0] tb_slope_table =
        {18'd0, 18'd0, 18'd0, 18'd127, 18'd16, 18'd16, 18'd16, 18'd16};
    localparam logic [143:0] tb_bias_table =
        {18'd0, 18'd0, 18'd0, 18'd120, 18'd48, 18'd32, 18'd16, 18'd0};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in;
    logic [0:0]        in_ch;
    logic              cfg_we;
    logic [0:0]        cfg_ch;
    logic [1:0]        cfg_setting;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out;
    logic [0:0]        out_ch;
    logic              clamp_lo;
    logic              clamp_hi;
    logic              sat;

    int                test_count = 0;
    int                fail_count = 0;
    logic [11:0]       sb_queue [$];
    int                model_setting [2] = '{0, 0};

    int model_slope [8] = '{16, 16, 16, 16, 127, 0, 0, 0};
    int model_bias  [8] = '{0, 16, 32, 48, 120, 0, 0, 0};

    pwl_pipe_mc #(
        .n_ch(2), .n_settings(2), .setting_width(2),
        .in_width(8), .in_point(4), .addr_width(2), .addr_offset(8),
        .segment_width(3), .slope_width(18), .slope_point(4),
        .bias_width(18), .out_width(8), .out_point(4),
        .slope_table(tb_slope_table), .bias_table(tb_bias_table)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in(in), .in_ch(in_ch),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_setting(cfg_setting),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_ch(out_ch),
        .clamp_lo(clamp_lo), .clamp_hi(clamp_hi), .sat(sat)
    );

    always #5 clk = ~clk;

    // Hard stop in case something upstream of the bounded waits hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: result packed as {out, ch, clamp_lo, clamp_hi, sat}.
    function automatic logic [11:0] expectResult(int in_val, int setting, int ch);
        int idx, addr, off, k, sum;
        logic lo, hi, s;
        logic [7:0] o;
        idx = in_val - 8;
        lo = 1'b0;
        hi = 1'b0;
        s  = 1'b0;
        if (idx < 0) begin
            addr = 0; off = 0; lo = 1'b1;
        end else if (idx >= 32) begin
            addr = 3; off = 7; hi = 1'b1;
        end else begin
            addr = idx / 8; off = idx % 8;
        end
        k = setting * 4 + addr;
        sum = model_bias[k] + ((model_slope[k] * off) >>> 4);
        if (sum > 127) begin
            sum = 127; s = 1'b1;
        end else if (sum < -128) begin
            sum = -128; s = 1'b1;
        end
        o = sum[7:0];
        return {o, ch[0], lo, hi, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: retire results on output handshakes, queue expectations
    // on input handshakes, then apply configuration writes to the model so
    // a same-cycle accept sees the old setting.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_queue.delete();
            model_setting = '{0, 0};
        end else begin
            if (out_valid && out_ready) begin
                checkOutput("sb_nonempty", 32'(sb_queue.size() != 0), 32'd1);
                if (sb_queue.size() != 0) begin
                    checkOutput("result", {20'd0, out, out_ch, clamp_lo, clamp_hi, sat},
                                {20'd0, sb_queue.pop_front()});
                end
            end
            if (in_valid && in_ready) begin
                sb_queue.push_back(expectResult(int'(in), model_setting[in_ch], int'(in_ch)));
            end
            if (cfg_we) begin
                model_setting[cfg_ch] = (cfg_setting > 2'd1) ? 1 : int'(cfg_setting);
            end
        end
    end

    // Offer one sample (optionally with a config write) and return one
    // step after the edge that accepted it; back-to-back calls stream.
    task automatic applyStimulus(input int in_val, input int ch, input logic we,
                                 input int c_ch, input int c_set);
        logic done;
        done        = 1'b0;
        in          = 8'(in_val);
        in_ch       = 1'(ch);
        cfg_we      = we;
        cfg_ch      = 1'(c_ch);
        cfg_setting = 2'(c_set);
        in_valid    = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        checkOutput("accept", 32'(done), 32'd1);
    endtask

    task automatic checkLatency(input string tag);
        @(posedge clk); #1;
        checkOutput({tag, "_e1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_e2"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_e3"}, 32'(out_valid), 32'd1);
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 40 && sb_queue.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        checkOutput(tag, 32'(sb_queue.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    int stall_vals [8] = '{9, 17, 25, 33, 12, 20, 28, 36};
    int edge_vals  [5] = '{4, 40, 39, 8, 7};

    initial begin
        int  k;
        logic accepted;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in          = '0;
        in_ch       = '0;
        cfg_we      = 1'b0;
        cfg_ch      = '0;
        cfg_setting = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out", {20'd0, out, out_ch, clamp_lo, clamp_hi, sat}, 32'd0);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        // Single sample and its latency.
        applyStimulus(13, 0, 1'b0, 0, 0);
        checkLatency("lat");
        waitDrain("drain_single");

        // Back-to-back samples come out on consecutive cycles.
        applyStimulus(19, 1, 1'b0, 0, 0);
        applyStimulus(13, 1, 1'b0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("b2b_first", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        checkOutput("b2b_second", 32'(out_valid), 32'd1);
        waitDrain("drain_b2b");

        // Range boundaries on both sides.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(edge_vals[i], 0, 1'b0, 0, 0);
        end
        waitDrain("drain_edges");

        // Same-edge config write uses the old setting; the next one saturates.
        applyStimulus(15, 0, 1'b1, 0, 1);
        applyStimulus(15, 0, 1'b0, 0, 0);
        waitDrain("drain_cfg");

        // Out-of-range setting clamps to the last table.
        applyStimulus(8, 1, 1'b1, 1, 3);
        applyStimulus(8, 1, 1'b1, 0, 0);
        applyStimulus(10, 1, 1'b0, 0, 0);
        waitDrain("drain_clamp");

        // Output stall with a continuous input stream.
        out_ready = 1'b0;
        k         = 0;
        in        = 8'(stall_vals[0]);
        in_ch     = 1'(0);
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (out_valid && !out_ready && sb_queue.size() != 0) begin
                checkOutput("stall_hold", {20'd0, out, out_ch, clamp_lo, clamp_hi, sat},
                            {20'd0, sb_queue[0]});
            end
            accepted = in_valid && in_ready;
            @(posedge clk); #1;
            if (accepted && k < 7) begin
                k++;
                in    = 8'(stall_vals[k]);
                in_ch = 1'(k % 2);
            end
        end
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_queued", 32'(sb_queue.size()), 32'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain("drain_stall");

        // Reset with samples in flight.
        applyStimulus(13, 0, 1'b1, 0, 1);
        applyStimulus(19, 1, 1'b0, 0, 0);
        applyStimulus(27, 0, 1'b0, 0, 0);
        applyStimulus(35, 1, 1'b0, 0, 0);
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_async_out", {20'd0, out, out_ch, clamp_lo, clamp_hi, sat}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checkOutput("post_reset_quiet", 32'(out_valid), 32'd0);
        end

        // Settings were cleared: setting 0 gives 7, not a saturated 127.
        applyStimulus(15, 0, 1'b0, 0, 0);
        checkLatency("lat_after_reset");
        waitDrain("drain_after_reset");

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
